// File: rtl/mem_xlate_ctl_pkg.sv
// ============================================================================
// mem_xlate_ctl_pkg : shared encodings for the memory-access controller
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_xlate_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XLATE = 2'd1,
    ST_BUS   = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] c_sz_byte = 2'd0;
  localparam logic [1:0] c_sz_half = 2'd1;
  localparam logic [1:0] c_sz_word = 2'd2;

  localparam logic [2:0] c_exc_none   = 3'd0;
  localparam logic [2:0] c_exc_adel   = 3'd1;
  localparam logic [2:0] c_exc_ades   = 3'd2;
  localparam logic [2:0] c_exc_tlbl   = 3'd3;
  localparam logic [2:0] c_exc_tlbs   = 3'd4;
  localparam logic [2:0] c_exc_mod    = 3'd5;
  localparam logic [2:0] c_exc_buserr = 3'd6;

  localparam logic [2:0]  c_seg_kseg0     = 3'b100;
  localparam logic [2:0]  c_seg_kseg1     = 3'b101;
  localparam logic [31:0] c_unmapped_mask = 32'h1FFF_FFFF;

  // Size 3 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      c_sz_byte: return 1'b0;
      c_sz_half: return addr_lo[0];
      default:   return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_xlate_ctl_lane_align.sv
// ============================================================================
// mem_lane_align : little-endian byte-lane enables, store replication, load extraction
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
  import mem_xlate_ctl_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_shifted = i_rdata >> {i_addr_lo, 3'b000};
    w_byte    = w_shifted[7:0];
    w_half    = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_be      = 4'b1111;
    o_wdata   = i_wdata;
    o_rdata   = i_rdata;
    case (i_size)
      c_sz_byte: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
      end
      c_sz_half: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_signed & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_xlate_ctl.sv
// ============================================================================
// mem_xlate_ctl : segment classify, MMU lookup and single bus transaction per request
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_xlate_ctl
  import mem_xlate_ctl_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        res,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_vaddr,
  input  logic [31:0] req_wdata,
  input  logic        kernel_mode,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [2:0]  resp_exc,
  output logic [31:0] resp_badvaddr,
  output logic        mmu_addrValid,
  output logic [31:0] mmu_vAddr,
  input  logic [31:0] mmu_pAddr,
  input  logic        mmu_tlbMiss,
  input  logic        mmu_tlbInvalid,
  input  logic        mmu_tlbModified,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [15:0] c_bus_timeout = 16'(BUS_TIMEOUT);

  state_e      r_state, w_state_nxt;
  logic        r_write, r_signed;
  logic [1:0]  r_size;
  logic [31:0] r_vaddr, r_wdata, r_paddr, r_rdata;
  logic [2:0]  r_exc;
  logic [15:0] r_cnt;

  logic        w_accept, w_addr_err, w_unmapped, w_tlb_exc, w_timeout;
  logic [15:0] w_cnt_inc;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep, w_rdata_ext;

  assign w_accept   = (r_state == ST_IDLE) && req_valid;
  assign w_addr_err = is_misaligned(req_size, req_vaddr[1:0]) || (!kernel_mode && req_vaddr[31]);
  assign w_unmapped = (req_vaddr[31:29] == c_seg_kseg0) || (req_vaddr[31:29] == c_seg_kseg1);
  assign w_tlb_exc  = mmu_tlbMiss || mmu_tlbInvalid || (r_write && mmu_tlbModified);
  assign w_cnt_inc  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign w_timeout  = w_cnt_inc >= c_bus_timeout;

  always_ff @(posedge clk or posedge res) begin
    if (res) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_addr_err)      w_state_nxt = ST_RESP;
          else if (w_unmapped) w_state_nxt = ST_BUS;
          else                 w_state_nxt = ST_XLATE;
        end
      end
      ST_XLATE: w_state_nxt = w_tlb_exc ? ST_RESP : ST_BUS;
      ST_BUS:   if (bus_ack || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= 2'd0;
      r_vaddr  <= 32'd0;
      r_wdata  <= 32'd0;
      r_paddr  <= 32'd0;
      r_rdata  <= 32'd0;
      r_exc    <= c_exc_none;
      r_cnt    <= 16'd0;
    end else begin
      if (w_accept) begin
        r_write  <= req_write;
        r_signed <= req_signed;
        r_size   <= req_size;
        r_vaddr  <= req_vaddr;
        r_wdata  <= req_wdata;
        r_paddr  <= req_vaddr & c_unmapped_mask;
        r_rdata  <= 32'd0;
        r_exc    <= w_addr_err ? (req_write ? c_exc_ades : c_exc_adel) : c_exc_none;
        r_cnt    <= 16'd0;
      end
      if (r_state == ST_XLATE) begin
        r_cnt <= 16'd0;
        if (mmu_tlbMiss || mmu_tlbInvalid) r_exc   <= r_write ? c_exc_tlbs : c_exc_tlbl;
        else if (r_write && mmu_tlbModified) r_exc <= c_exc_mod;
        else                                 r_paddr <= mmu_pAddr;
      end
      // Ack takes priority over a coincident timeout.
      if (r_state == ST_BUS) begin
        if (bus_ack)        r_rdata <= r_write ? 32'd0 : w_rdata_ext;
        else if (w_timeout) r_exc   <= c_exc_buserr;
        else                r_cnt   <= w_cnt_inc;
      end
    end
  end

  mem_lane_align u_lane_align (
    .i_size    (r_size),
    .i_addr_lo (r_paddr[1:0]),
    .i_signed  (r_signed),
    .i_wdata   (r_wdata),
    .i_rdata   (bus_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata_rep),
    .o_rdata   (w_rdata_ext)
  );

  always_comb begin
    req_ready     = (r_state == ST_IDLE);
    resp_valid    = (r_state == ST_RESP);
    resp_rdata    = resp_valid ? r_rdata : 32'd0;
    resp_exc      = resp_valid ? r_exc : c_exc_none;
    resp_badvaddr = (resp_valid && r_exc != c_exc_none) ? r_vaddr : 32'd0;
    mmu_addrValid = (r_state == ST_XLATE);
    mmu_vAddr     = mmu_addrValid ? r_vaddr : 32'd0;
    bus_req       = (r_state == ST_BUS);
    bus_we        = bus_req && r_write;
    bus_addr      = bus_req ? {r_paddr[31:2], 2'b00} : 32'd0;
    bus_be        = bus_req ? w_be : 4'd0;
    bus_wdata     = bus_we ? w_wdata_rep : 32'd0;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_xlate_ctl.sv
// ============================================================================
// tb_mem_xlate_ctl : randomized bench with a request-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_xlate_ctl;

  localparam int c_tmo = 4;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0, kernel_mode = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_vaddr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, mmu_addrValid, bus_req, bus_we;
  logic [31:0] resp_rdata, resp_badvaddr, mmu_vAddr, bus_addr, bus_wdata;
  logic [2:0]  resp_exc;
  logic [3:0]  bus_be;
  logic [31:0] mmu_pAddr = 32'd0, bus_rdata = 32'd0;
  logic        mmu_tlbMiss = 1'b0, mmu_tlbInvalid = 1'b0, mmu_tlbModified = 1'b0, bus_ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_rdata, last_addr, last_bad;
  logic [3:0]  last_be;
  logic [2:0]  last_exc;

  always #5 clk = ~clk;

  mem_xlate_ctl #(.BUS_TIMEOUT(c_tmo)) dut (
    .clk(clk), .res(res),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_vaddr(req_vaddr),
    .req_wdata(req_wdata), .kernel_mode(kernel_mode),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
    .resp_badvaddr(resp_badvaddr),
    .mmu_addrValid(mmu_addrValid), .mmu_vAddr(mmu_vAddr), .mmu_pAddr(mmu_pAddr),
    .mmu_tlbMiss(mmu_tlbMiss), .mmu_tlbInvalid(mmu_tlbInvalid),
    .mmu_tlbModified(mmu_tlbModified),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request end to end. ackd = BUS cycle index that carries the ack (>= c_tmo never acks).
  task automatic run_req(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] va,
                         input logic [31:0] wd, input bit k, input bit miss, input bit inv,
                         input bit mod, input logic [31:0] pa, input int ackd, input logic [31:0] rd);
    bit          aerr, unm, tlbx, exp_mmu, exp_bus, got, saw_mmu, saw_bus;
    logic [2:0]  e_exc;
    logic [31:0] e_pa, e_rd, e_wd, lane;
    logic [3:0]  e_be;
    int          e_lat, base, bcyc;

    aerr = (sz == 2'd1 && va[0]) || (sz[1] && va[1:0] != 2'd0) || (!k && va[31]);
    unm  = va[31:30] == 2'b10;
    tlbx = miss || inv || (w && mod);
    e_exc = 3'd0;
    e_pa  = 32'd0;
    base  = 0;
    if (aerr) begin
      e_exc = w ? 3'd2 : 3'd1; e_lat = 1;
    end else if (unm) begin
      e_pa = va % 32'h2000_0000; base = 1;
    end else if (miss || inv) begin
      e_exc = w ? 3'd4 : 3'd3; e_lat = 2;
    end else if (w && mod) begin
      e_exc = 3'd5; e_lat = 2;
    end else begin
      e_pa = pa; base = 2;
    end
    exp_mmu = !aerr && !unm;
    exp_bus = !aerr && (unm || !tlbx);
    if (exp_bus) begin
      if (ackd < c_tmo) e_lat = base + ackd + 1;
      else begin e_lat = base + c_tmo; e_exc = 3'd6; end
    end
    case (sz)
      2'd0: begin e_be = 4'd1 << va[1:0]; e_wd = {24'd0, wd[7:0]} * 32'h0101_0101; end
      2'd1: begin e_be = va[1] ? 4'b1100 : 4'b0011; e_wd = {16'd0, wd[15:0]} * 32'h0001_0001; end
      default: begin e_be = 4'b1111; e_wd = wd; end
    endcase
    e_rd = 32'd0;
    if (!w && e_exc == 3'd0) begin
      case (sz)
        2'd0: begin
          lane = (rd / (32'd1 << (8 * va[1:0]))) % 256;
          e_rd = (sg && lane >= 128) ? lane + 32'hFFFF_FF00 : lane;
        end
        2'd1: begin
          lane = va[1] ? rd / 65536 : rd % 65536;
          e_rd = (sg && lane >= 32768) ? lane + 32'hFFFF_0000 : lane;
        end
        default: e_rd = rd;
      endcase
    end

    @(negedge clk);
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_vaddr = va; req_wdata = wd; kernel_mode = k;
    mmu_pAddr = pa; mmu_tlbMiss = miss; mmu_tlbInvalid = inv; mmu_tlbModified = mod;
    bus_rdata = rd; bus_ack = $urandom_range(0, 1) == 1;
    got = 0; saw_mmu = 0; saw_bus = 0; bcyc = 0;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req_valid = 1'b0; req_vaddr = $urandom; req_wdata = $urandom;
        req_write = $urandom_range(0, 1) == 1; req_size = 2'($urandom);
      end
      check("ready_busy", {31'd0, req_ready}, 32'd0);
      if (resp_valid) begin
        got = 1;
        check("latency", n, e_lat);
        check("resp_exc", {29'd0, resp_exc}, {29'd0, e_exc});
        check("resp_rdata", resp_rdata, e_rd);
        if (e_exc != 3'd0) check("badvaddr", resp_badvaddr, va);
        last_rdata = resp_rdata; last_exc = resp_exc; last_bad = resp_badvaddr;
        bus_ack = 1'b0;
      end else begin
        if (mmu_addrValid) begin
          saw_mmu = 1;
          check("mmu_vaddr", mmu_vAddr, va);
        end
        if (bus_req) begin
          saw_bus = 1;
          check("bus_addr", bus_addr, {e_pa[31:2], 2'b00});
          check("bus_be", {28'd0, bus_be}, {28'd0, e_be});
          check("bus_we", {31'd0, bus_we}, {31'd0, w});
          if (w) check("bus_wdata", bus_wdata, e_wd);
          last_addr = bus_addr; last_be = bus_be;
          bus_ack = (bcyc == ackd);
          bcyc++;
        end else begin
          bus_ack = $urandom_range(0, 1) == 1;
        end
      end
    end
    if (!got) check("resp_timeout", 32'd0, 32'd1);
    check("saw_mmu", {31'd0, saw_mmu}, {31'd0, exp_mmu});
    check("saw_bus", {31'd0, saw_bus}, {31'd0, exp_bus});
    bus_ack = 1'b0;
  endtask

  initial begin
    bit          w, sg, k, miss, inv, mod;
    logic [1:0]  sz;
    logic [31:0] va, pa;
    int          seg;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_mmu_valid", {31'd0, mmu_addrValid}, 32'd0);
    check("rst_bus_be", {28'd0, bus_be}, 32'd0);
    res = 1'b0;

    run_req(0, 2'd2, 0, 32'h8000_1004, 32'd0, 1, 0, 0, 0, 32'd0, 0, 32'hDEAD_BEEF);
    check("plan_unm_addr", last_addr, 32'h0000_1004);
    check("plan_unm_be", {28'd0, last_be}, 32'hF);
    check("plan_unm_rdata", last_rdata, 32'hDEAD_BEEF);
    run_req(0, 2'd0, 1, 32'h0040_0003, 32'd0, 1, 0, 0, 0, 32'h0123_4003, 0, 32'h8012_3456);
    check("plan_map_addr", last_addr, 32'h0123_4000);
    check("plan_map_be", {28'd0, last_be}, 32'h8);
    check("plan_map_rdata", last_rdata, 32'hFFFF_FF80);
    run_req(1, 2'd1, 0, 32'h0000_0001, 32'h1234, 1, 0, 0, 0, 32'd0, 0, 32'd0);
    check("plan_ades", {29'd0, last_exc}, 32'd2);
    check("plan_ades_bad", last_bad, 32'h0000_0001);
    run_req(0, 2'd2, 0, 32'hA000_0000, 32'd0, 0, 0, 0, 0, 32'd0, 0, 32'd0);
    check("plan_user_adel", {29'd0, last_exc}, 32'd1);
    run_req(1, 2'd2, 0, 32'h0000_1000, 32'h55, 1, 1, 0, 0, 32'h0000_1000, 0, 32'd0);
    check("plan_tlbs", {29'd0, last_exc}, 32'd4);
    run_req(1, 2'd2, 0, 32'h0000_2000, 32'h55, 1, 0, 0, 1, 32'h0000_2000, 0, 32'd0);
    check("plan_mod", {29'd0, last_exc}, 32'd5);
    run_req(0, 2'd2, 0, 32'h8000_0040, 32'd0, 1, 0, 0, 0, 32'd0, 99, 32'd0);
    check("plan_buserr", {29'd0, last_exc}, 32'd6);
    run_req(0, 2'd1, 1, 32'h0000_3002, 32'd0, 1, 0, 0, 0, 32'h0000_7002, c_tmo - 1, 32'h9ABC_0000);
    check("ack_beats_tmo", {29'd0, last_exc}, 32'd0);

    // Reset while a bus transaction is outstanding.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_vaddr = 32'h8000_0100; kernel_mode = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_bus_req", {31'd0, bus_req}, 32'd1);
    @(negedge clk);
    #2 res = 1'b1;
    #1 check("rst_drops_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_ready_async", {31'd0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    res = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("no_resp_after_rst", {31'd0, resp_valid}, 32'd0);
    end
    run_req(0, 2'd0, 0, 32'h8000_0102, 32'd0, 1, 0, 0, 0, 32'd0, 1, 32'h00AB_0000);
    check("post_rst_rdata", last_rdata, 32'h0000_00AB);

    for (int i = 0; i < 150; i++) begin
      w = $urandom_range(0, 1) == 1; sg = $urandom_range(0, 1) == 1;
      k = $urandom_range(0, 3) != 0; sz = 2'($urandom);
      seg = $urandom_range(0, 3);
      case (seg)
        0: va = $urandom & 32'h7FFF_FFFF;
        1: va = 32'h8000_0000 | ($urandom & 32'h1FFF_FFFF);
        2: va = 32'hA000_0000 | ($urandom & 32'h1FFF_FFFF);
        default: va = 32'hC000_0000 | ($urandom & 32'h3FFF_FFFF);
      endcase
      if ($urandom_range(0, 2) != 0) va = va & ~((sz == 2'd0) ? 32'd0 : (sz == 2'd1) ? 32'd1 : 32'd3);
      miss = $urandom_range(0, 5) == 0; inv = $urandom_range(0, 5) == 0; mod = $urandom_range(0, 4) == 0;
      pa = ($urandom & 32'hFFFF_FFFC) | {30'd0, va[1:0]};
      run_req(w, sz, sg, va, $urandom, k, miss, inv, mod, pa, $urandom_range(0, 5), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
